// File: rtl/tenyr_mem_arbiter.sv
// tenyr_mem_arbiter: shares one synchronous memory between fetch and data ports, data-first with starvation guard.
// Optional protocol checker on err enabled by TENYR_MEMARB_PROTOCHECK_EN.
module tenyr_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_data,
  input  logic                  d_req,
  input  logic                  d_rw,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  busy,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [3:0] MAXS = 4'(MAX_STARVE);
  localparam logic [2:0] LAST = 3'(LATENCY - 1);
  state_t                state_q, state_d;
  logic [1:0]            own_q, own_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, idata_q, idata_d, drdata_q, drdata_d;
  logic [2:0]            lat_q, lat_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  gnt_d, gnt_i;
  assign gnt_d = d_req && !(i_req && cnt_q == MAXS);
  assign gnt_i = i_req && !gnt_d;
  // own bit 0 = fetch owns the memory, bit 1 = data owns it
  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    idata_d  = idata_q;
    drdata_d = drdata_q;
    lat_d    = lat_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (i_req || d_req) begin
        state_d = ISSUE;
        own_d   = {gnt_d, gnt_i};
        rw_d    = gnt_d && d_rw;
        addr_d  = gnt_d ? d_addr : i_addr;
        wdata_d = gnt_d ? d_wdata : wdata_q;
        cnt_d   = gnt_i ? 4'd0 : (i_req && cnt_q != MAXS) ? cnt_q + 4'd1 : cnt_q;
      end
      ISSUE: begin
        state_d = rw_q ? DONE : WAIT;
        lat_d   = 3'd0;
      end
      WAIT: begin
        lat_d = lat_q + 3'd1;
        if (lat_q == LAST) begin
          state_d  = DONE;
          idata_d  = own_q[0] ? m_rdata : idata_q;
          drdata_d = own_q[1] ? m_rdata : drdata_q;
        end
      end
      default: begin
        state_d = IDLE;
        own_d   = 2'b00;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      own_q    <= 2'b00;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      idata_q  <= '0;
      drdata_q <= '0;
      lat_q    <= 3'd0;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      idata_q  <= idata_d;
      drdata_q <= drdata_d;
      lat_q    <= lat_d;
      cnt_q    <= cnt_d;
    end
  end
  assign m_en    = state_q == ISSUE;
  assign m_we    = m_en && rw_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_ack   = state_q == DONE && own_q[0];
  assign d_ack   = state_q == DONE && own_q[1];
  assign i_data  = idata_q;
  assign d_rdata = drdata_q;
  assign busy    = state_q != IDLE;
`ifdef TENYR_MEMARB_PROTOCHECK_EN
  logic err_q, viol;
  // compare the owner's live request against what was latched at grant
  assign viol = (state_q == ISSUE || state_q == WAIT) &&
    (own_q[1] ? (!d_req || d_rw != rw_q || d_addr != addr_q || d_wdata != wdata_q)
              : (!i_req || i_addr != addr_q));
  always_ff @(posedge clk) err_q <= reset ? 1'b0 : (err_q || viol);
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_tenyr_mem_arbiter.sv
// tb_tenyr_mem_arbiter: vector table plus directed sequences for two arbiter instances (LATENCY 1 and 3).
module tb_tenyr_mem_arbiter;
`ifdef TENYR_MEMARB_PROTOCHECK_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif
  logic clk = 0, reset = 1;
  logic i_req = 0, d_req = 0, d_rw = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic i_ack1, d_ack1, m_en1, m_we1, busy1, err1;
  logic [31:0] i_data1, d_rdata1, m_addr1, m_wdata1;
  logic i_ack3, d_ack3, m_en3, m_we3, busy3, err3;
  logic [31:0] i_data3, d_rdata3, m_addr3, m_wdata3;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  tenyr_mem_arbiter #(.LATENCY(1), .MAX_STARVE(4)) dut1 (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack1), .i_data(i_data1),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack1), .d_rdata(d_rdata1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata),
    .busy(busy1), .err(err1));
  tenyr_mem_arbiter #(.LATENCY(3), .MAX_STARVE(4)) dut3 (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack3), .i_data(i_data3),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack3), .d_rdata(d_rdata3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata),
    .busy(busy3), .err(err3));

  typedef struct {
    logic ir; logic [31:0] ia; logic dr, rw; logic [31:0] da, dw, rd;
    logic men, mwe; logic [31:0] ma, mw; logic iak, dak, bsy; logic [31:0] id, dd;
  } vec_t;
  vec_t tv[14];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; i_req = 0; d_req = 0; d_rw = 0; i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] ord;
    int acks;
    logic prev_men;
    tv[0]  = '{1, 32'h100, 0, 0, 0, 0, 0,                   0, 0, 0,     0,            0, 0, 0, 0,            0};
    tv[1]  = '{1, 32'h100, 0, 0, 0, 0, 0,                   1, 0, 32'h100, 0,          0, 0, 1, 0,            0};
    tv[2]  = '{1, 32'h100, 0, 0, 0, 0, 32'hDEADBEEF,        0, 0, 32'h100, 0,          0, 0, 1, 0,            0};
    tv[3]  = '{1, 32'h100, 0, 0, 0, 0, 0,                   0, 0, 32'h100, 0,          1, 0, 1, 32'hDEADBEEF, 0};
    tv[4]  = '{0, 32'h100, 0, 0, 0, 0, 0,                   0, 0, 32'h100, 0,          0, 0, 0, 32'hDEADBEEF, 0};
    tv[5]  = '{0, 0, 1, 1, 32'h20, 32'h12345678, 0,         0, 0, 32'h100, 0,          0, 0, 0, 32'hDEADBEEF, 0};
    tv[6]  = '{0, 0, 1, 1, 32'h20, 32'h12345678, 0,         1, 1, 32'h20, 32'h12345678, 0, 0, 1, 32'hDEADBEEF, 0};
    tv[7]  = '{0, 0, 1, 1, 32'h20, 32'h12345678, 0,         0, 0, 32'h20, 32'h12345678, 0, 1, 1, 32'hDEADBEEF, 0};
    tv[8]  = '{0, 0, 0, 0, 0, 0, 0,                         0, 0, 32'h20, 32'h12345678, 0, 0, 0, 32'hDEADBEEF, 0};
    tv[9]  = '{0, 0, 1, 0, 32'h44, 0, 0,                    0, 0, 32'h20, 32'h12345678, 0, 0, 0, 32'hDEADBEEF, 0};
    tv[10] = '{0, 0, 1, 0, 32'h44, 0, 0,                    1, 0, 32'h44, 0,           0, 0, 1, 32'hDEADBEEF, 0};
    tv[11] = '{0, 0, 1, 0, 32'h44, 0, 32'hCAFEF00D,         0, 0, 32'h44, 0,           0, 0, 1, 32'hDEADBEEF, 0};
    tv[12] = '{0, 0, 1, 0, 32'h44, 0, 0,                    0, 0, 32'h44, 0,           0, 1, 1, 32'hDEADBEEF, 32'hCAFEF00D};
    tv[13] = '{0, 0, 0, 0, 0, 0, 0,                         0, 0, 32'h44, 0,           0, 0, 0, 32'hDEADBEEF, 32'hCAFEF00D};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy1", 32'(busy1), 0);
    chk("rst m_en1", 32'(m_en1), 0);
    chk("rst m_addr1", m_addr1, 0);
    chk("rst acks1", 32'({i_ack1, d_ack1}), 0);
    chk("rst data1", i_data1 | d_rdata1, 0);
    chk("rst busy3", 32'(busy3), 0);
    chk("rst err3", 32'(err3), 0);

    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      reset = 0;
      i_req = tv[k].ir; i_addr = tv[k].ia; d_req = tv[k].dr; d_rw = tv[k].rw;
      d_addr = tv[k].da; d_wdata = tv[k].dw; m_rdata = tv[k].rd;
      @(negedge clk);
      chk($sformatf("v%0d m_en", k), 32'(m_en1), 32'(tv[k].men));
      chk($sformatf("v%0d m_we", k), 32'(m_we1), 32'(tv[k].mwe));
      chk($sformatf("v%0d m_addr", k), m_addr1, tv[k].ma);
      chk($sformatf("v%0d m_wdata", k), m_wdata1, tv[k].mw);
      chk($sformatf("v%0d i_ack", k), 32'(i_ack1), 32'(tv[k].iak));
      chk($sformatf("v%0d d_ack", k), 32'(d_ack1), 32'(tv[k].dak));
      chk($sformatf("v%0d busy", k), 32'(busy1), 32'(tv[k].bsy));
      chk($sformatf("v%0d i_data", k), i_data1, tv[k].id);
      chk($sformatf("v%0d d_rdata", k), d_rdata1, tv[k].dd);
      chk($sformatf("v%0d err", k), 32'(err1), 0);
    end

    // contention: both requesters held, writes on the data side
    do_reset();
    i_req = 1; i_addr = 32'h200; d_req = 1; d_rw = 1; d_addr = 32'h30; d_wdata = 32'h77;
    ord = 0; acks = 0; prev_men = 0;
    for (int c = 0; c < 80 && acks < 10; c++) begin
      @(negedge clk);
      chk("starve one-ack", 32'(i_ack1 && d_ack1), 0);
      chk("starve m_en gap", 32'(m_en1 && prev_men), 0);
      prev_men = m_en1;
      if (i_ack1 || d_ack1) begin
        ord = {ord[8:0], i_ack1};
        acks++;
      end
    end
    chk("starve ack count", acks, 10);
    chk("starve order", 32'(ord), 32'(10'b0000100001));
    @(posedge clk); #1;
    i_req = 0; d_req = 0;

    // reset while a read is in WAIT, then a clean read
    do_reset();
    d_req = 1; d_rw = 0; d_addr = 32'h80; m_rdata = 32'h5A5A0001;
    @(negedge clk); chk("mr c0 busy", 32'(busy1), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("mr c1 m_en", 32'(m_en1), 1);
    @(posedge clk); #1; reset = 1;
    @(negedge clk); chk("mr c2 busy", 32'(busy1), 1);
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    chk("mr c3 busy", 32'(busy1), 0);
    chk("mr c3 d_ack", 32'(d_ack1), 0);
    chk("mr c3 m_addr", m_addr1, 0);
    chk("mr c3 d_rdata", d_rdata1, 0);
    for (int c = 4; c <= 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("mr c%0d d_ack", c), 32'(d_ack1), 32'(c == 6));
    end
    chk("mr d_rdata", d_rdata1, 32'h5A5A0001);
    @(posedge clk); #1; d_req = 0;

    // LATENCY=3 read: data sampled from the cycle-4 memory word
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      d_req = (k <= 5); d_rw = 0; d_addr = 32'h40; m_rdata = 32'h1000 + 32'(k);
      @(negedge clk);
      chk($sformatf("l3 c%0d d_ack", k), 32'(d_ack3), 32'(k == 5));
      chk($sformatf("l3 c%0d m_en", k), 32'(m_en3), 32'(k == 1));
      if (k == 1) chk("l3 m_addr", m_addr3, 32'h40);
      if (k == 5) chk("l3 d_rdata", d_rdata3, 32'h1004);
    end

    // req dropped during WAIT: transaction still completes; err depends on build
    do_reset();
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      d_req = (k <= 1); d_rw = 0; d_addr = 32'h40; m_rdata = 32'hABCD0000 + 32'(k);
      @(negedge clk);
      chk($sformatf("pc c%0d d_ack", k), 32'(d_ack3), 32'(k == 5));
      chk($sformatf("pc c%0d err", k), 32'(err3), 32'(PC && k >= 3));
    end
    chk("pc d_rdata", d_rdata3, 32'hABCD0004);
    do_reset();
    @(negedge clk);
    chk("pc err after reset", 32'(err3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
